// File: rtl/mtx_seq_ctrl.sv
// mtx_seq_ctrl: burst sequencer for the modulator TX path.
// Walks IDLE -> ARM -> SYNC (NSYNC phases) -> TX (NTX_SEGS segments),
// gating generator I/Q and driving the generator/hop resets and GPIO flags.
module mtx_seq_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int CNT_WIDTH      = 24,
    parameter int GPIO_REG_WIDTH = 12,
    parameter int NSYNC          = 4,
    parameter int SEG_LEN        = 8256,
    parameter int NTX_SEGS       = 16,
    parameter logic [7:0] SYNC_PATTERN  = 8'b0000_0110,
    parameter logic [7:0] BLANK_PATTERN = 8'b0000_0100,
    parameter int HOP_REL_PHASE  = 2,
    parameter int SRST_REL_PHASE = 3,
    parameter logic [GPIO_REG_WIDTH-1:0] SYNC_MASK = 12'h001,
    parameter logic [GPIO_REG_WIDTH-1:0] TX_MASK   = 12'h800,
    localparam int TSEG_W = $clog2(NTX_SEGS + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      mode_cont,
    input  logic                      sig_ready,
    input  logic [DATA_WIDTH-1:0]     i_in,
    input  logic [DATA_WIDTH-1:0]     q_in,
    input  logic                      out_tready,
    output logic [DATA_WIDTH-1:0]     itx,
    output logic [DATA_WIDTH-1:0]     qtx,
    output logic                      tx_valid,
    output logic                      gen_srst,
    output logic                      hop_rst,
    output logic [GPIO_REG_WIDTH-1:0] gpio_out,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                phase_idx,
    output logic [TSEG_W-1:0]         tx_seg,
    output logic [CNT_WIDTH-1:0]      sample_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SYNC, ST_TX} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(SEG_LEN - 1);
    localparam logic [2:0]           PHASE_LAST = 3'(NSYNC - 1);
    localparam logic [TSEG_W-1:0]    SEG_LAST   = TSEG_W'(NTX_SEGS - 1);
    localparam logic [2:0]           HOP_REL    = 3'(HOP_REL_PHASE);
    localparam logic [2:0]           SRST_REL   = 3'(SRST_REL_PHASE);

    state_t               state_q, state_d;
    logic [2:0]           phase_q, phase_d;
    logic [TSEG_W-1:0]    tx_seg_q, tx_seg_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic                 done_q, done_d;
    logic                 seg_end;

    // A segment (or sync phase) ends on the beat that carries its last sample.
    assign seg_end = out_tready && (cnt_q == CNT_LAST);

    // State and counter registers; reset returns everything to an idle, cleared sequencer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            tx_seg_q <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            tx_seg_q <= tx_seg_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    // Next-state and counter update; abort overrides every other transition.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        tx_seg_d = tx_seg_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                    mode_d  = mode_cont;
                end
            end
            ST_ARM: begin
                if (sig_ready) begin
                    state_d = ST_SYNC;
                    phase_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_SYNC: begin
                if (seg_end) begin
                    cnt_d = '0;
                    if (phase_q == PHASE_LAST) begin
                        state_d  = ST_TX;
                        phase_d  = '0;
                        tx_seg_d = '0;
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end else if (out_tready) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_TX: begin
                if (seg_end) begin
                    cnt_d = '0;
                    if (tx_seg_q == SEG_LAST) begin
                        tx_seg_d = '0;
                        phase_d  = '0;
                        if (mode_q) begin
                            state_d = ST_SYNC;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        tx_seg_d = tx_seg_q + 1'b1;
                    end
                end else if (out_tready) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d  = ST_IDLE;
            phase_d  = '0;
            tx_seg_d = '0;
            cnt_d    = '0;
            done_d   = 1'b0;
        end
    end

    // Output decode from the registered state; I/Q gating is combinational.
    always_comb begin
        tx_valid = 1'b0;
        gen_srst = 1'b1;
        hop_rst  = 1'b1;
        gpio_out = '0;
        unique case (state_q)
            ST_SYNC: begin
                gpio_out = (SYNC_PATTERN[phase_q] ? SYNC_MASK : '0) |
                           (BLANK_PATTERN[phase_q] ? '0 : TX_MASK);
                tx_valid = ~BLANK_PATTERN[phase_q];
                hop_rst  = (phase_q < HOP_REL);
                gen_srst = (phase_q < SRST_REL);
            end
            ST_TX: begin
                gpio_out = TX_MASK;
                tx_valid = 1'b1;
                gen_srst = 1'b0;
                hop_rst  = 1'b0;
            end
            default: begin
                tx_valid = 1'b0;
            end
        endcase
        itx = tx_valid ? i_in : '0;
        qtx = tx_valid ? q_in : '0;
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign phase_idx  = phase_q;
    assign tx_seg     = tx_seg_q;
    assign sample_cnt = cnt_q;

endmodule
